mb32_booth_r8_top: RTL and testbench
====================================

// Module: mb32_booth_r8_top
// PURPOSE
//  Pipelined 32x32 unsigned multiplier using radix-8 Booth partial products.
//  Takes multiplier mx already recoded into 11 Booth digits (s/d/t/q/n), multiplicand my and precomputed 3*my.
//  Returns the exact 64-bit product 3 clocks later. One new operand set is accepted every cycle.
//  Encoder booth_r8_encode sits upstream (combinational, mx -> digits).
// PARAMETERS
//  WIDTH      32                  operand width
//  GROUP_CNT  (WIDTH>>2)+3 = 11   Booth digit count (covers bits -1..32 of zero-extended mx)
// PORTS
//  CLK      in   1          single clock, rising edge
//  RST      in   1          synchronous, active-low reset (sampled on CLK rise)
//  s        in   GROUP_CNT  digit i magnitude 1
//  d        in   GROUP_CNT  digit i magnitude 2
//  t        in   GROUP_CNT  digit i magnitude 3
//  q        in   GROUP_CNT  digit i magnitude 4
//  n        in   GROUP_CNT  digit i negative
//  my       in   WIDTH      multiplicand
//  tmy      in   WIDTH+2    3*my, 34 bits, supplied by caller
//  s2,d2,t2,q2,n2  out  GROUP_CNT  stage-1 registered copies of s,d,t,q,n
//  my2      out  WIDTH      stage-1 registered my
//  tmy2     out  WIDTH+2    stage-1 registered tmy
//  product  out  2*WIDTH    registered unsigned product
// BEHAVIOUR
//  - Digit i = (n[i] ? -1 : +1) * (s?1 : d?2 : t?3 : q?4 : 0). At most one of s/d/t/q is set per group.
//    All-zero magnitude gives 0 regardless of n.
//  - Encoder definition: b[-1]=0 and b[k>=32]=0.
//    digit_i = -4*b[3i+2] + 2*b[3i+1] + b[3i] + b[3i-1].
//    n[i] = b[3i+2] && magnitude!=0. Group 10 is never negative.
//  - PP_i = digit_i*my. Source is my, my<<1, tmy or my<<2, selected by magnitude.
//    PP_i is 35 bits and weighted by 2^(3i).
//    Negation: one's complement plus a correction bit n[i] injected at weight 2^(3i).
//    Sign extension uses the constant-correction (frozen) scheme.
//  - product = sum(PP_i) mod 2^64. This must equal mx*my exactly for all unsigned 32-bit operands.
//  - Pipeline, all regs on CLK rise, 1 result/cycle:
//    E1: capture inputs into the *2 regs.
//    E2: PP generation + carry-save reduction into sum/carry regs.
//    E3: final carry-propagate add into product.
//  - Latency: inputs stable before edge N -> product valid after edge N+2, held until edge N+3.
//  - Reset: RST=0 at an edge clears every register, including all outputs and the internal sum/carry.
//    Reset mid-operation discards all in-flight results. The first valid product appears 3 edges after RST returns to 1.
//  - No handshake and no stall. tmy != 3*my is a caller error; the result is then undefined.
// CONFIGURATION
//  MB32_SELF_CHECK_EN defined:
//    - Simulation-only checks each cycle after reset:
//      - tmy2 == 3*my2;
//      - at most one of s2/d2/t2/q2 set per group;
//      - n2[10]==0.
//    - Each violation issues $error.
//  Undefined: no checks. Synthesized logic is identical either way.
// STRUCTURE
//  Package mb32_pkg:
//    - WIDTH, GROUP_CNT, PP_W=WIDTH+3;
//    - digit struct {s,d,t,q,n};
//    - sign-correction constant.
//  Sub-module booth_r8_encode (mx -> s,d,t,q,n) in the same file, combinational, used upstream and by the bench.
//  The top contains the PP selector, the CSA tree and the final adder.
// TESTING
//  1. mx=0, my=0xFFFFFFFF -> product 0x0 at latency 3.
//  2. mx=7, my=3 -> 0x15. Digits: g0=-1, g1=+1, rest 0.
//  3. mx=my=0xFFFFFFFF -> 0xFFFFFFFE00000001. Exercises max digits and corrections.
//  4. mx=0x80000000, my=2 -> 0x0000000100000000. Then mx=0x12345678, my=0x9ABCDEF0 -> 0x0B00EA4E242D2080.
//  5. 10000 random back-to-back pairs, one per cycle, with tmy=3*my -> every product == mx*my 3 edges later, 0 errors.
//  6. RST=0 for 1 edge mid-stream -> product and *2 outputs 0 after that edge; correct results resume 3 edges after release.

Source files
------------

// File: rtl/mb32_pkg.sv
// Shared widths, Booth digit type and carry-save helpers for the radix-8 Booth multiplier.
package mb32_pkg;

  localparam int WIDTH     = 32;
  localparam int GROUP_CNT = (WIDTH >> 2) + 3;
  localparam int PP_W      = WIDTH + 3;
  localparam int PROD_W    = 2 * WIDTH;

  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } digit_t;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] cy;
  } csa_t;

  // Each PP is stored with its sign bit inverted, which adds 2^(PP_W-1) per group; this removes it.
  function automatic logic [PROD_W-1:0] sign_corr_calc();
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < GROUP_CNT; i++) begin
      if (PP_W - 1 + 3 * i < PROD_W) acc = acc - (PROD_W'(1) << (PP_W - 1 + 3 * i));
    end
    return acc;
  endfunction

  localparam logic [PROD_W-1:0] SIGN_CORR = sign_corr_calc();

  function automatic csa_t csa3(input logic [PROD_W-1:0] a, input logic [PROD_W-1:0] b,
                                input logic [PROD_W-1:0] c);
    csa_t r;
    r.sum = a ^ b ^ c;
    r.cy  = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/mb32_booth_r8_top.sv
// 32x32 unsigned radix-8 Booth multiplier: 3-stage pipeline, one op per cycle, never stalls (no backpressure).
// Define MB32_SELF_CHECK_EN for simulation-only checks on the registered operands.
module booth_r8_encode
  import mb32_pkg::*;
(
  input  logic [WIDTH-1:0]     i_mx,
  output logic [GROUP_CNT-1:0] o_s,
  output logic [GROUP_CNT-1:0] o_d,
  output logic [GROUP_CNT-1:0] o_t,
  output logic [GROUP_CNT-1:0] o_q,
  output logic [GROUP_CNT-1:0] o_n
);

  // w_b[k+1] holds b[k]; b[-1] and everything above bit WIDTH-1 read as zero.
  logic [3*GROUP_CNT:0] w_b;
  assign w_b = {{(3 * GROUP_CNT - WIDTH){1'b0}}, i_mx, 1'b0};

  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_enc
    logic [2:0] w_val;
    logic [2:0] w_mag;
    logic       w_neg;

    assign w_val = {1'b0, w_b[3*g+2], 1'b0} + {2'b0, w_b[3*g+1]} + {2'b0, w_b[3*g]};
    assign w_neg = w_b[3*g+3];
    assign w_mag = w_neg ? (3'd4 - w_val) : w_val;

    assign o_s[g] = (w_mag == 3'd1);
    assign o_d[g] = (w_mag == 3'd2);
    assign o_t[g] = (w_mag == 3'd3);
    assign o_q[g] = (w_mag == 3'd4);
    assign o_n[g] = w_neg && (w_mag != 3'd0);
  end

endmodule

module mb32_booth_r8_top
  import mb32_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [GROUP_CNT-1:0] i_s,
  input  logic [GROUP_CNT-1:0] i_d,
  input  logic [GROUP_CNT-1:0] i_t,
  input  logic [GROUP_CNT-1:0] i_q,
  input  logic [GROUP_CNT-1:0] i_n,
  input  logic [WIDTH-1:0]     i_my,
  input  logic [WIDTH+1:0]     i_tmy,
  output logic [GROUP_CNT-1:0] o_s2,
  output logic [GROUP_CNT-1:0] o_d2,
  output logic [GROUP_CNT-1:0] o_t2,
  output logic [GROUP_CNT-1:0] o_q2,
  output logic [GROUP_CNT-1:0] o_n2,
  output logic [WIDTH-1:0]     o_my2,
  output logic [WIDTH+1:0]     o_tmy2,
  output logic [PROD_W-1:0]    o_product
);

  logic [GROUP_CNT-1:0] r_s2, r_d2, r_t2, r_q2, r_n2;
  logic [WIDTH-1:0]     r_my2;
  logic [WIDTH+1:0]     r_tmy2;
  logic [PROD_W-1:0]    r_sum, r_cy, r_product;

  logic [PROD_W-1:0]    w_op [GROUP_CNT+1];
  logic [PROD_W-1:0]    w_corr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2   <= '0;
      r_d2   <= '0;
      r_t2   <= '0;
      r_q2   <= '0;
      r_n2   <= '0;
      r_my2  <= '0;
      r_tmy2 <= '0;
    end else begin
      r_s2   <= i_s;
      r_d2   <= i_d;
      r_t2   <= i_t;
      r_q2   <= i_q;
      r_n2   <= i_n;
      r_my2  <= i_my;
      r_tmy2 <= i_tmy;
    end
  end

  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_pp
    digit_t          w_dig;
    logic [PP_W-1:0] w_mag;
    logic [PP_W-1:0] w_pp;

    assign w_dig = '{s: r_s2[g], d: r_d2[g], t: r_t2[g], q: r_q2[g], n: r_n2[g]};

    always_comb begin
      w_mag = '0;
      if (w_dig.s)      w_mag = {3'b0, r_my2};
      else if (w_dig.d) w_mag = {2'b0, r_my2, 1'b0};
      else if (w_dig.t) w_mag = {1'b0, r_tmy2};
      else if (w_dig.q) w_mag = {1'b0, r_my2, 2'b0};
    end

    assign w_pp     = w_dig.n ? ~w_mag : w_mag;
    assign w_op[g]  = PROD_W'({~w_pp[PP_W-1], w_pp[PP_W-2:0]}) << (3 * g);
  end

  // The +1 completions of the negated PPs sit at bits 3i, all below the lowest bit of SIGN_CORR.
  always_comb begin
    w_corr = SIGN_CORR;
    for (int g = 0; g < GROUP_CNT; g++) w_corr[3*g] = r_n2[g];
  end
  assign w_op[GROUP_CNT] = w_corr;

  // 12 -> 8 -> 6 -> 4 -> 3 -> 2 carry-save reduction.
  csa_t w_l1 [4];
  csa_t w_l2a, w_l2b, w_l3a, w_l3b, w_l4, w_l5;

  for (genvar k = 0; k < 4; k++) begin : g_l1
    assign w_l1[k] = csa3(w_op[3*k], w_op[3*k+1], w_op[3*k+2]);
  end

  assign w_l2a = csa3(w_l1[0].sum, w_l1[0].cy, w_l1[1].sum);
  assign w_l2b = csa3(w_l1[1].cy, w_l1[2].sum, w_l1[2].cy);
  assign w_l3a = csa3(w_l2a.sum, w_l2a.cy, w_l2b.sum);
  assign w_l3b = csa3(w_l2b.cy, w_l1[3].sum, w_l1[3].cy);
  assign w_l4  = csa3(w_l3a.sum, w_l3a.cy, w_l3b.sum);
  assign w_l5  = csa3(w_l4.sum, w_l4.cy, w_l3b.cy);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum     <= '0;
      r_cy      <= '0;
      r_product <= '0;
    end else begin
      r_sum     <= w_l5.sum;
      r_cy      <= w_l5.cy;
      r_product <= r_sum + r_cy;
    end
  end

`ifdef MB32_SELF_CHECK_EN
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (r_tmy2 != ({2'b0, r_my2} + {1'b0, r_my2, 1'b0}))
        $error("tmy2 %h is not 3*my2 (my2 %h)", r_tmy2, r_my2);
      for (int g = 0; g < GROUP_CNT; g++) begin
        if ($countones({r_s2[g], r_d2[g], r_t2[g], r_q2[g]}) > 1)
          $error("group %0d has more than one magnitude bit set", g);
      end
      if (r_n2[GROUP_CNT-1])
        $error("top Booth group flagged negative");
    end
  end
`endif

  assign o_s2      = r_s2;
  assign o_d2      = r_d2;
  assign o_t2      = r_t2;
  assign o_q2      = r_q2;
  assign o_n2      = r_n2;
  assign o_my2     = r_my2;
  assign o_tmy2    = r_tmy2;
  assign o_product = r_product;

endmodule

// File: tb/tb_mb32_booth_r8_top.sv
// Randomized self-checking bench: products compared against plain 64-bit mx*my, three edges after issue.
module tb_mb32_booth_r8_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mx, my;
  logic [33:0] tmy;
  logic [10:0] s, d, t, q, n;
  logic [10:0] s2, d2, t2, q2, n2;
  logic [31:0] my2;
  logic [33:0] tmy2;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  // Expected product for each edge still in flight, oldest first, with a label for reporting.
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  booth_r8_encode u_enc (
    .i_mx(mx), .o_s(s), .o_d(d), .o_t(t), .o_q(q), .o_n(n)
  );

  mb32_booth_r8_top dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s(s), .i_d(d), .i_t(t), .i_q(q), .i_n(n),
    .i_my(my), .i_tmy(tmy),
    .o_s2(s2), .o_d2(d2), .o_t2(t2), .o_q2(q2), .o_n2(n2),
    .o_my2(my2), .o_tmy2(tmy2), .o_product(product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    mx  = a;
    my  = b;
    tmy = {2'b0, b} * 34'd3;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Pipeline empties to zero products after any reset edge.
  task automatic flush_model();
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(64'h0); tag_q.push_back("post_reset_0");
    exp_q.push_back(64'h0); tag_q.push_back("post_reset_1");
  endtask

  task automatic test_reset();
    logic [63:0] e;
    string       tg;
    rst_n = 1'b0;
    set_ops(32'hDEADBEEF, 32'h0BADF00D);
    tick();
    tick();
    checks++;
    if (product !== 64'h0) begin
      errors++; $display("FAIL reset_product got %h expected 0", product);
    end
    checks++;
    if ({s2, d2, t2, q2, n2} !== 55'h0) begin
      errors++; $display("FAIL reset_digits got %h expected 0", {s2, d2, t2, q2, n2});
    end
    checks++;
    if ({my2, tmy2} !== 66'h0) begin
      errors++; $display("FAIL reset_operands got %h expected 0", {my2, tmy2});
    end
    rst_n = 1'b1;
    flush_model();
    set_ops(32'h0, 32'h0);
    exp_q.push_back(64'h0); tag_q.push_back("reset_idle");
    tick();
    e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
    if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
  endtask

  task automatic test_zero();
    logic [63:0] e;
    string       tg;
    set_ops(32'h0, 32'hFFFFFFFF);
    exp_q.push_back(64'h0); tag_q.push_back("zero_mx");
    tick();
    e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
    if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
  endtask

  task automatic test_small();
    logic [63:0] e;
    string       tg;
    set_ops(32'd7, 32'd3);
    #1;
    // 7 recodes to digits -1 (group 0) and +1 (group 1).
    checks++;
    if ({s, d, t, q, n} !== {11'b011, 11'b0, 11'b0, 11'b0, 11'b001}) begin
      errors++; $display("FAIL enc_7 got s=%b d=%b t=%b q=%b n=%b expected s=011 n=001", s, d, t, q, n);
    end
    exp_q.push_back(64'h15); tag_q.push_back("mul_7x3");
    tick();
    e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
    if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
    checks++;
    if (s2 !== 11'b011 || n2 !== 11'b001 || my2 !== 32'd3 || tmy2 !== 34'd9) begin
      errors++; $display("FAIL stage1_capture got s2=%b n2=%b my2=%h tmy2=%h expected 011 001 3 9", s2, n2, my2, tmy2);
    end
  endtask

  task automatic test_max();
    logic [63:0] e;
    string       tg;
    set_ops(32'hFFFFFFFF, 32'hFFFFFFFF);
    #1;
    // All ones: group 0 is -1, middle groups cancel to 0, top group is +4.
    checks++;
    if ({s, d, t, q, n} !== {11'b1, 11'b0, 11'b0, 11'b100_0000_0000, 11'b1}) begin
      errors++; $display("FAIL enc_max got s=%b d=%b t=%b q=%b n=%b", s, d, t, q, n);
    end
    exp_q.push_back(64'hFFFFFFFE00000001); tag_q.push_back("mul_max");
    tick();
    e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
    if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
  endtask

  task automatic test_vectors();
    logic [63:0] e;
    string       tg;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vp [4];
    va = '{32'h80000000, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};
    vb = '{32'h00000002, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000001};
    vp = '{64'h0000000100000000, 64'h0B00EA4E242D2080, 64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      set_ops(va[i], vb[i]);
      exp_q.push_back(vp[i]); tag_q.push_back($sformatf("vector_%0d", i));
      tick();
      e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
      if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
    end
  endtask

  task automatic test_back_to_back(input int count);
    logic [63:0] e;
    string       tg;
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hFFFFFFFF;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h1 << $urandom_range(0, 31);
        default: ;
      endcase
      set_ops(a, b);
      exp_q.push_back(ref_mul(a, b)); tag_q.push_back($sformatf("random_%0d", i));
      tick();
      e = exp_q.pop_front(); tg = tag_q.pop_front(); checks++;
      if (product !== e) begin errors++; $display("FAIL %s product got %h expected %h", tg, product, e); end
      checks++;
      if (my2 !== b || tmy2 !== ({2'b0, b} * 34'd3)) begin
        errors++; $display("FAIL capture_%0d my2=%h tmy2=%h expected my=%h", i, my2, tmy2, b);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_back_to_back(20);
    rst_n = 1'b0;
    set_ops($urandom, $urandom);
    tick();
    checks++;
    if (product !== 64'h0) begin
      errors++; $display("FAIL midreset_product got %h expected 0", product);
    end
    checks++;
    if ({s2, d2, t2, q2, n2, my2, tmy2} !== 121'h0) begin
      errors++; $display("FAIL midreset_stage1 got %h expected 0", {s2, d2, t2, q2, n2, my2, tmy2});
    end
    rst_n = 1'b1;
    flush_model();
    test_back_to_back(20);
  endtask

  initial begin
    rst_n = 1'b0;
    set_ops(32'h0, 32'h0);
    test_reset();
    test_zero();
    test_small();
    test_max();
    test_vectors();
    test_back_to_back(10000);
    test_reset_mid();
    test_zero();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
